// File: rtl/mix_columns_iter.sv
// mix_columns_iter
//   Iterative AES/Rijndael MixColumns unit, forward and inverse modes.
//   A state block of NB 32-bit columns is accepted over a valid/ready
//   handshake, transformed COLS_PER_CYCLE columns per clock in a work
//   register, and presented on a held valid/ready output.
//
// Parameters
//   NB              state columns (4..8); block width = 32*NB
//   COLS_PER_CYCLE  columns transformed per clock; must divide NB
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_data/in_inv valid
//   in_ready   out  block can be accepted
//   in_inv     in   0 = MixColumns, 1 = InvMixColumns
//   in_data    in   state, column 0 in the top 32 bits, byte b0 = column MSB
//   out_valid  out  out_data holds a finished block
//   out_ready  in   downstream accepts out_data
//   out_data   out  transformed state, same layout as in_data
//   busy       out  high while columns are being transformed
//
// Configuration macro
//   MIXCOL_BACK2BACK_EN  when defined, a new block may be accepted in the
//                        same cycle the finished block is handed off
//                        (DONE -> BUSY with no idle bubble).

module mix_columns_iter #(
  parameter int NB             = 4,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_inv,
  input  logic [32*NB-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*NB-1:0] out_data,
  output logic            busy
);

  localparam int unsigned W  = 32 * NB;
  localparam int unsigned CW = $clog2(NB + 1);

  generate
    if (COLS_PER_CYCLE < 1 || NB < 4 || NB > 8 || (NB % COLS_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("mix_columns_iter: NB must be 4..8 and divisible by COLS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q,     state_d;
  logic [CW-1:0]   col_cnt_q,   col_cnt_d;
  logic [W-1:0]    work_q,      work_d;
  logic            mode_q,      mode_d;
  logic            out_valid_q, out_valid_d;

  // GF(2^8) multiply by 2, reduction polynomial 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
  endfunction

  // One column through the forward {02,03,01,01} or inverse {0e,0b,0d,09}
  // circulant; row r uses the coefficient row rotated right by r.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  b  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [7:0]  t;
    logic [31:0] res;
    int unsigned i0, i1, i2, i3;
    res = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      b[i]  = col[31-8*i -: 8];
      x2[i] = xtime(b[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int unsigned r = 0; r < 4; r++) begin
      i0 = r;
      i1 = (r + 1) % 4;
      i2 = (r + 2) % 4;
      i3 = (r + 3) % 4;
      if (inv) begin
        t = (x8[i0] ^ x4[i0] ^ x2[i0])   // 0e
          ^ (x8[i1] ^ x2[i1] ^ b[i1])    // 0b
          ^ (x8[i2] ^ x4[i2] ^ b[i2])    // 0d
          ^ (x8[i3] ^ b[i3]);            // 09
      end else begin
        t = x2[i0] ^ (x2[i1] ^ b[i1]) ^ b[i2] ^ b[i3];
      end
      res[31-8*r -: 8] = t;
    end
    return res;
  endfunction

  // in_ready is decoded from the registered state (plus out_ready in the
  // back-to-back build) so the accept decision needs no extra flop.
`ifdef MIXCOL_BACK2BACK_EN
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
`else
  assign in_ready = (state_q == IDLE);
`endif

  assign out_valid = out_valid_q;
  assign out_data  = work_q;
  assign busy      = (state_q == BUSY);

  always_comb begin
    int unsigned pos;
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    work_d      = work_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    pos         = 0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = BUSY;
          work_d    = in_data;
          mode_d    = in_inv;
          col_cnt_d = '0;
        end
      end

      BUSY: begin
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
          pos = 32'(col_cnt_q) + j;
          work_d[W-32-32*pos +: 32] = mix_col(work_q[W-32-32*pos +: 32], mode_q);
        end
        col_cnt_d = col_cnt_q + CW'(COLS_PER_CYCLE);
        if (col_cnt_q == CW'(NB - COLS_PER_CYCLE)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef MIXCOL_BACK2BACK_EN
          // Hand-off and new accept on the same edge skip the IDLE cycle.
          if (in_valid) begin
            state_d   = BUSY;
            work_d    = in_data;
            mode_d    = in_inv;
            col_cnt_d = '0;
          end
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_cnt_q   <= '0;
      work_q      <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      work_q      <= work_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
